timer_dev: RTL and testbench

//   Memory-mapped programmable down-counter on the processor bridge. It is the

---
 rtl/timer_dev.sv | 145 ++++++++++++++
 tb/tb_timer_dev.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped programmable down-counter with an interrupt output.
//
// Ports:
//   clk    - single clock, all state changes on the rising edge
//   reset  - asynchronous, active-high; clears all state immediately
//   Addr   - bridge address; [31:4] decode against BASE_ADDR, [3:2] select register
//   WE     - bridge write enable
//   DIn    - write data
//   DOut   - read data, combinational from Addr (0 on a non-hit)
//   IRQ    - registered interrupt request (pending & IM)
//
// Register map (offset = Addr[3:2]):
//   0 CTRL   [0] En, [2:1] Mode, [3] IM
//   1 PRESET [CNT_W-1:0]
//   2 COUNT  read only
//   3 --     reads 0
module timer_dev #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter int          CNT_W     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] DIn,
    output logic [31:0] DOut,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CNT  = 2'd1,
        INT  = 2'd2
    } state_t;

    state_t             state, state_d;
    logic               en, en_d;
    logic [1:0]         mode, mode_d;
    logic               im, im_d;
    logic [CNT_W-1:0]   preset, preset_d;
    logic [CNT_W-1:0]   count, count_d;
    logic               pending, pending_d;

    logic hit, wr_ctrl, wr_preset;
    logic unused_bits;

    assign hit       = (Addr[31:4] == BASE_ADDR[31:4]);
    assign wr_ctrl   = WE && hit && (Addr[3:2] == 2'd0);
    assign wr_preset = WE && hit && (Addr[3:2] == 2'd1);

    // Byte-offset bits never participate in decode.
    assign unused_bits = ^{Addr[1:0], DIn};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            en      <= 1'b0;
            mode    <= 2'd0;
            im      <= 1'b0;
            preset  <= '0;
            count   <= '0;
            pending <= 1'b0;
            IRQ     <= 1'b0;
        end else begin
            state   <= state_d;
            en      <= en_d;
            mode    <= mode_d;
            im      <= im_d;
            preset  <= preset_d;
            count   <= count_d;
            pending <= pending_d;
            // IRQ follows the next-state pending so it rises on the same edge
            // pending is set, i.e. PRESET+2 edges after the enabling write.
            IRQ     <= pending_d & im_d;
        end
    end

    always_comb begin
        state_d   = state;
        en_d      = en;
        mode_d    = mode;
        im_d      = im;
        preset_d  = preset;
        count_d   = count;
        pending_d = pending;

        // Auto-reload mode produces a single-cycle pending pulse.
        if (pending && mode == 2'd1)
            pending_d = 1'b0;

        case (state)
            IDLE: begin
                if (en) begin
                    count_d = preset;
                    state_d = CNT;
                end
            end
            CNT: begin
                if (!en)
                    state_d = IDLE;          // COUNT frozen
                else if (count > CNT_W'(1))
                    count_d = count - CNT_W'(1);
                else begin
                    // PRESET=0 lands here too, so it behaves like PRESET=1.
                    count_d = '0;
                    state_d = INT;
                end
            end
            INT: begin
                pending_d = 1'b1;
                state_d   = IDLE;
                if (mode != 2'd1)
                    en_d = 1'b0;             // one-shot; modes 2/3 alias mode 0
            end
            default: state_d = IDLE;
        endcase

        // Bus writes take priority over the FSM on the same edge.
        if (wr_ctrl) begin
            en_d   = DIn[0];
            mode_d = DIn[2:1];
            im_d   = DIn[3];
        end
        if (wr_preset)
            preset_d = DIn[CNT_W-1:0];
        if (wr_ctrl || wr_preset) begin
            state_d   = IDLE;
            pending_d = 1'b0;
            count_d   = count;
        end
    end

    always_comb begin
        DOut = '0;
        if (hit) begin
            case (Addr[3:2])
                2'd0:    DOut = {28'd0, im, mode, en};
                2'd1:    DOut = 32'(preset);
                2'd2:    DOut = 32'(count);
                default: DOut = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: one-shot, auto-reload, masked interrupt,
// freeze/reload, register decode, and asynchronous reset.
module tb_timer_dev;

    localparam logic [31:0] BASE   = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_PRE  = BASE + 32'h4;
    localparam logic [31:0] A_CNT  = BASE + 32'h8;
    localparam logic [31:0] A_RSV  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] DIn;
    logic [31:0] DOut;
    logic        IRQ;

    int n_chk  = 0;
    int n_pass = 0;

    timer_dev #(.BASE_ADDR(BASE), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .DIn   (DIn),
        .DOut  (DOut),
        .IRQ   (IRQ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Write lands on the next rising edge; returns 1 time unit after it.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        Addr = a; DIn = d; WE = 1'b1;
        @(posedge clk);
        #1 WE = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        Addr = a;
        #1 d = DOut;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] v;

    initial begin
        reset = 1'b1; Addr = A_CTRL; WE = 1'b0; DIn = '0;
        step(2);
        // reset state
        rd(A_CTRL, v); chk("rst_ctrl", v, 32'h0);
        rd(A_PRE,  v); chk("rst_preset", v, 32'h0);
        rd(A_CNT,  v); chk("rst_count", v, 32'h0);
        chk("rst_irq", {31'd0, IRQ}, 32'h0);
        @(negedge clk); reset = 1'b0;

        // 1: one-shot, PRESET=5
        wr(A_PRE, 32'd5);
        wr(A_CTRL, 32'h9);
        rd(A_CNT, v); chk("t1_cnt_e0", v, 32'd0);
        for (int k = 0; k < 6; k++) begin
            step(1);
            rd(A_CNT, v); chk($sformatf("t1_cnt_e%0d", k + 1), v, 32'(5 - k));
        end
        chk("t1_irq_e6", {31'd0, IRQ}, 32'h0);
        step(1);
        chk("t1_irq_e7", {31'd0, IRQ}, 32'h1);
        step(3);
        chk("t1_irq_sticky", {31'd0, IRQ}, 32'h1);
        rd(A_CNT, v);  chk("t1_cnt_final", v, 32'd0);
        rd(A_CTRL, v); chk("t1_ctrl", v, 32'h8);

        // 2: auto-reload, PRESET=3, pulses every 5 cycles
        wr(A_PRE, 32'd3);
        chk("t2_irq_cleared", {31'd0, IRQ}, 32'h0);
        wr(A_CTRL, 32'hB);
        step(4);
        chk("t2_irq_e4", {31'd0, IRQ}, 32'h0);
        for (int p = 0; p < 3; p++) begin
            step(1);
            chk($sformatf("t2_pulse%0d_hi", p), {31'd0, IRQ}, 32'h1);
            rd(A_CTRL, v); chk($sformatf("t2_ctrl%0d", p), v, 32'hB);
            step(1);
            chk($sformatf("t2_pulse%0d_lo", p), {31'd0, IRQ}, 32'h0);
            step(3);
            chk($sformatf("t2_gap%0d", p), {31'd0, IRQ}, 32'h0);
        end
        wr(A_CTRL, 32'h0);

        // 3: IM=0, one-shot, PRESET=2
        wr(A_PRE, 32'd2);
        wr(A_CTRL, 32'h1);
        step(6);
        chk("t3_irq_masked", {31'd0, IRQ}, 32'h0);
        rd(A_CNT, v);  chk("t3_cnt", v, 32'd0);
        rd(A_CTRL, v); chk("t3_ctrl", v, 32'h0);
        wr(A_CTRL, 32'h8);
        chk("t3_irq_after_im", {31'd0, IRQ}, 32'h0);
        step(2);
        chk("t3_irq_later", {31'd0, IRQ}, 32'h0);

        // 4: freeze at 6, then reload 10
        wr(A_PRE, 32'd10);
        wr(A_CTRL, 32'h9);
        step(5);
        rd(A_CNT, v); chk("t4_cnt6", v, 32'd6);
        wr(A_CTRL, 32'h8);
        rd(A_CNT, v); chk("t4_frozen", v, 32'd6);
        step(3);
        rd(A_CNT, v); chk("t4_frozen_later", v, 32'd6);
        wr(A_CTRL, 32'h9);
        step(1);
        rd(A_CNT, v); chk("t4_reload", v, 32'd10);
        wr(A_CTRL, 32'h8);
        rd(A_CNT, v); chk("t4_stop", v, 32'd10);

        // 5: decode and read-only registers
        wr(A_CNT, 32'h1234);
        wr(A_RSV, 32'hFFFF_FFFF);
        wr(32'h0000_7E00, 32'h9);
        @(negedge clk); Addr = A_CTRL; DIn = 32'h3; WE = 1'b0;
        step(2);
        rd(A_CNT, v);  chk("t5_cnt", v, 32'd10);
        rd(A_CTRL, v); chk("t5_ctrl", v, 32'h8);
        rd(A_PRE, v);  chk("t5_preset", v, 32'd10);
        rd(A_RSV, v);  chk("t5_rsv", v, 32'h0);
        rd(32'h0000_7F10, v); chk("t5_nohit", v, 32'h0);

        // 6: async reset mid-count, then while IRQ high
        wr(A_PRE, 32'd6);
        wr(A_CTRL, 32'h9);
        step(3);
        rd(A_CNT, v); chk("t6_cnt4", v, 32'd4);
        reset = 1'b1;
        rd(A_CNT, v);  chk("t6_rst_cnt", v, 32'h0);
        rd(A_CTRL, v); chk("t6_rst_ctrl", v, 32'h0);
        rd(A_PRE, v);  chk("t6_rst_pre", v, 32'h0);
        chk("t6_rst_irq", {31'd0, IRQ}, 32'h0);
        chk("t6_rst_state", {30'd0, dut.state}, 32'h0);
        @(negedge clk); reset = 1'b0;
        step(3);
        rd(A_CNT, v); chk("t6_idle_cnt", v, 32'h0);
        wr(A_PRE, 32'd1);
        wr(A_CTRL, 32'h9);
        step(3);
        chk("t6_irq_hi", {31'd0, IRQ}, 32'h1);
        reset = 1'b1;
        #1;
        chk("t6_rst2_irq", {31'd0, IRQ}, 32'h0);
        chk("t6_rst2_state", {30'd0, dut.state}, 32'h0);
        rd(A_CTRL, v); chk("t6_rst2_ctrl", v, 32'h0);
        @(negedge clk); reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
